mem_req_arbiter_2to1: RTL and testbench

- Shares one val/rdy memory request/response port between two requesters, e.g. two cache ports feeding a single-ported memory or one port of the 2-port test memory.
- Arbitration is round-robin with grant locking.
- Requests pass through with zero latency; the message is unmodified and the opaque field is preserved.
- Responses return in request order, so an in-order ID FIFO records the requester of each accepted request and steers each response back to it.

---
 rtl/mem_req_arbiter_2to1_pkg.sv | 32 +++
 rtl/mem_arb_id_fifo.sv | 66 ++++++
 rtl/mem_req_arbiter_2to1.sv | 124 ++++++++++++
 tb/tb_mem_req_arbiter_2to1.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_2to1_pkg.sv
// ============================================================================
// Module  : mem_req_arbiter_2to1_pkg
// Brief   : Memory message field widths and type codes shared by the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_req_arbiter_2to1_pkg;

    localparam int c_mem_type_nbits = 3;
    localparam int c_mem_test_nbits = 2;

    localparam logic [c_mem_type_nbits-1:0] c_mem_type_read  = 3'd0;
    localparam logic [c_mem_type_nbits-1:0] c_mem_type_write = 3'd1;

    // Request:  {type, opaque, addr, len, data}
    // Response: {type, opaque, test, len, data}
    function automatic int mem_len_nbits(input int data_nbits);
        return $clog2(data_nbits / 8);
    endfunction

    function automatic int mem_req_nbits(input int o, input int a, input int d);
        return c_mem_type_nbits + o + a + mem_len_nbits(d) + d;
    endfunction

    function automatic int mem_resp_nbits(input int o, input int d);
        return c_mem_type_nbits + o + c_mem_test_nbits + mem_len_nbits(d) + d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_id_fifo.sv
// ============================================================================
// Module  : mem_arb_id_fifo
// Brief   : In-order 1-bit requester-ID FIFO; no bypass, so full blocks enq
//           even when a dequeue happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enq_val,
    input  logic i_enq_data,
    input  logic i_deq_rdy,
    output logic o_deq_data,
    output logic o_full,
    output logic o_empty
);

    localparam int c_ptr_nbits = $clog2(DEPTH);
    localparam int c_cnt_nbits = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]       r_ids;
    logic [c_ptr_nbits-1:0] r_wr_ptr;
    logic [c_ptr_nbits-1:0] r_rd_ptr;
    logic [c_cnt_nbits-1:0] r_count;
    logic                   w_enq;
    logic                   w_deq;

    assign o_full     = (r_count == c_cnt_nbits'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_deq_data = r_ids[r_rd_ptr];
    assign w_enq      = i_enq_val & ~o_full;
    assign w_deq      = i_deq_rdy & ~o_empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ids    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_ids[r_wr_ptr] <= i_enq_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_nbits'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_nbits'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_nbits'(1);
                2'b01:   r_count <= r_count - c_cnt_nbits'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= c_cnt_nbits'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/mem_req_arbiter_2to1.sv
// ============================================================================
// Module  : mem_req_arbiter_2to1
// Brief   : Round-robin 2:1 val/rdy memory request arbiter with grant locking
//           and in-order response steering.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_arbiter_2to1
    import mem_req_arbiter_2to1_pkg::*;
#(
    parameter int P_OPAQUE_NBITS    = 8,
    parameter int P_ADDR_NBITS      = 32,
    parameter int P_DATA_NBITS      = 32,
    parameter int P_MAX_OUTSTANDING = 4,
    localparam int c_req_nbits  = mem_req_nbits(P_OPAQUE_NBITS, P_ADDR_NBITS, P_DATA_NBITS),
    localparam int c_resp_nbits = mem_resp_nbits(P_OPAQUE_NBITS, P_DATA_NBITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    i_req0_val,
    output logic                    o_req0_rdy,
    input  logic [c_req_nbits-1:0]  i_req0_msg,

    input  logic                    i_req1_val,
    output logic                    o_req1_rdy,
    input  logic [c_req_nbits-1:0]  i_req1_msg,

    output logic                    o_resp0_val,
    input  logic                    i_resp0_rdy,
    output logic [c_resp_nbits-1:0] o_resp0_msg,

    output logic                    o_resp1_val,
    input  logic                    i_resp1_rdy,
    output logic [c_resp_nbits-1:0] o_resp1_msg,

    output logic                    o_memreq_val,
    input  logic                    i_memreq_rdy,
    output logic [c_req_nbits-1:0]  o_memreq_msg,

    input  logic                    i_memresp_val,
    output logic                    o_memresp_rdy,
    input  logic [c_resp_nbits-1:0] i_memresp_msg
);

    logic r_prio;
    logic r_locked;
    logic r_lock_id;

    logic w_grant;
    logic w_gnt_val;
    logic w_fire;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_head_rdy;
    logic w_pop_rdy;

    // A locked grant holds the stalled message stable until memory accepts it.
    always_comb begin
        w_grant = 1'b0;
        if (r_locked) begin
            w_grant = r_lock_id;
        end else if (i_req0_val && i_req1_val) begin
            w_grant = r_prio;
        end else if (i_req1_val) begin
            w_grant = 1'b1;
        end
    end

    assign w_gnt_val    = w_grant ? i_req1_val : i_req0_val;
    assign o_memreq_msg = w_grant ? i_req1_msg : i_req0_msg;
    assign o_memreq_val = rst_n & w_gnt_val & ~w_full;
    assign o_req0_rdy   = rst_n & ~w_grant & i_memreq_rdy & ~w_full;
    assign o_req1_rdy   = rst_n &  w_grant & i_memreq_rdy & ~w_full;
    assign w_fire       = o_memreq_val & i_memreq_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio    <= 1'b0;
            r_locked  <= 1'b0;
            r_lock_id <= 1'b0;
        end else if (w_fire) begin
            r_prio   <= ~w_grant;
            r_locked <= 1'b0;
        end else if (o_memreq_val && !r_locked) begin
            r_locked  <= 1'b1;
            r_lock_id <= w_grant;
        end
    end

    // Memory answers in order, so the FIFO head names the response owner.
    assign w_head_rdy    = w_head ? i_resp1_rdy : i_resp0_rdy;
    assign o_memresp_rdy = rst_n & ~w_empty & w_head_rdy;
    assign w_pop_rdy     = rst_n & i_memresp_val & w_head_rdy;
    assign o_resp0_val   = rst_n & i_memresp_val & ~w_empty & ~w_head;
    assign o_resp1_val   = rst_n & i_memresp_val & ~w_empty &  w_head;
    assign o_resp0_msg   = i_memresp_msg;
    assign o_resp1_msg   = i_memresp_msg;

    mem_arb_id_fifo #(
        .DEPTH (P_MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_enq_val  (w_fire),
        .i_enq_data (w_grant),
        .i_deq_rdy  (w_pop_rdy),
        .o_deq_data (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    a_no_x_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({i_req0_val, i_req1_val, i_resp0_rdy, i_resp1_rdy,
                     i_memreq_rdy, i_memresp_val}));

    a_resp_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        i_memresp_val |-> !w_empty);

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter_2to1.sv
// ============================================================================
// Module  : tb_mem_req_arbiter_2to1
// Brief   : Directed self-checking bench for the 2:1 memory request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_req_arbiter_2to1;
    import mem_req_arbiter_2to1_pkg::*;

    localparam int c_req_nbits  = 77;
    localparam int c_resp_nbits = 47;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    req0_val, req1_val, resp0_rdy, resp1_rdy;
    logic                    memreq_rdy, memresp_val;
    logic [c_req_nbits-1:0]  req0_msg, req1_msg;
    logic [c_resp_nbits-1:0] memresp_msg;
    logic                    req0_rdy, req1_rdy, resp0_val, resp1_val;
    logic                    memreq_val, memresp_rdy;
    logic [c_resp_nbits-1:0] resp0_msg, resp1_msg;
    logic [c_req_nbits-1:0]  memreq_msg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_req_arbiter_2to1 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req0_val    (req0_val),
        .o_req0_rdy    (req0_rdy),
        .i_req0_msg    (req0_msg),
        .i_req1_val    (req1_val),
        .o_req1_rdy    (req1_rdy),
        .i_req1_msg    (req1_msg),
        .o_resp0_val   (resp0_val),
        .i_resp0_rdy   (resp0_rdy),
        .o_resp0_msg   (resp0_msg),
        .o_resp1_val   (resp1_val),
        .i_resp1_rdy   (resp1_rdy),
        .o_resp1_msg   (resp1_msg),
        .o_memreq_val  (memreq_val),
        .i_memreq_rdy  (memreq_rdy),
        .o_memreq_msg  (memreq_msg),
        .i_memresp_val (memresp_val),
        .o_memresp_rdy (memresp_rdy),
        .i_memresp_msg (memresp_msg)
    );

    function automatic logic [c_req_nbits-1:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                                     input logic [31:0] addr, input logic [31:0] data);
        return {t, op, addr, 2'd0, data};
    endfunction

    function automatic logic [c_resp_nbits-1:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                                       input logic [31:0] data);
        return {t, op, 2'd0, 2'd0, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_val = 0; req1_val = 0; resp0_rdy = 0; resp1_rdy = 0;
        memreq_rdy = 0; memresp_val = 0;
        req0_msg = '0; req1_msg = '0; memresp_msg = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [c_req_nbits-1:0] a;
        clear_inputs();
        rst_n = 1'b0;
        a = mk_req(c_mem_type_read, 8'h11, 32'h40, 32'h0);
        req0_val = 1; req1_val = 1; memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        req0_msg = a; req1_msg = mk_req(c_mem_type_read, 8'h22, 32'h80, 32'h0);
        tick();
        n_tests++;
        if ({memreq_val, req0_rdy, req1_rdy, memresp_rdy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000", {memreq_val, req0_rdy, req1_rdy, memresp_rdy});
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (memreq_msg !== a || memreq_val !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prio0: val %b msg %h expected 1 %h", memreq_val, memreq_msg, a);
        end
        clear_inputs();
    endtask

    task automatic test_single();
        logic [c_req_nbits-1:0]  a;
        logic [c_resp_nbits-1:0] r;
        do_reset();
        a = mk_req(c_mem_type_read, 8'h05, 32'h100, 32'h0);
        r = mk_resp(c_mem_type_read, 8'h05, 32'hCAFE_F00D);
        req0_val = 1; req0_msg = a; memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        #1;
        n_tests++;
        if (memreq_val !== 1'b1 || memreq_msg !== a || {req1_rdy, req0_rdy} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_req: val %b msg %h rdy %b expected 1 %h 01", memreq_val, memreq_msg, {req1_rdy, req0_rdy}, a);
        end
        tick();
        req0_val = 0;
        memresp_val = 1; memresp_msg = r;
        #1;
        n_tests++;
        if ({resp1_val, resp0_val, memresp_rdy} !== 3'b011 || resp0_msg !== r) begin
            n_fail++;
            $display("FAIL single_resp: r1/r0/mrdy %b msg %h expected 011 %h", {resp1_val, resp0_val, memresp_rdy}, resp0_msg, r);
        end
        tick();
        memresp_val = 0;
        #1;
        n_tests++;
        if (memresp_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: memresp_rdy %b expected 0", memresp_rdy);
        end
    endtask

    task automatic test_alternate();
        int g0, g1, exp_g, exp_r;
        g0 = 0; g1 = 0;
        do_reset();
        memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1; req0_val = 1; req1_val = 1;
        for (int k = 0; k < 8; k++) begin
            req0_msg = mk_req(c_mem_type_read, 8'(k), 32'h1000 + 32'(k), 32'h0);
            req1_msg = mk_req(c_mem_type_read, 8'(8'h80 + k), 32'h2000 + 32'(k), 32'h0);
            memresp_val = (k > 0);
            memresp_msg = mk_resp(c_mem_type_read, 8'(k), 32'(k));
            #1;
            exp_g = k % 2;
            n_tests++;
            if (memreq_msg !== (exp_g == 1 ? req1_msg : req0_msg) ||
                {req1_rdy, req0_rdy} !== (exp_g == 1 ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL alt_grant[%0d]: rdy %b expected grant %0d", k, {req1_rdy, req0_rdy}, exp_g);
            end
            if (req0_rdy) g0++;
            if (req1_rdy) g1++;
            if (k > 0) begin
                exp_r = (k - 1) % 2;
                n_tests++;
                if ({resp1_val, resp0_val} !== (exp_r == 1 ? 2'b10 : 2'b01) || memresp_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL alt_resp[%0d]: r1r0 %b mrdy %b expected side %0d", k, {resp1_val, resp0_val}, memresp_rdy, exp_r);
                end
            end
            tick();
        end
        req0_val = 0; req1_val = 0;
        memresp_val = 1;
        #1;
        n_tests++;
        if ({resp1_val, resp0_val} !== 2'b10) begin
            n_fail++;
            $display("FAIL alt_last_resp: r1r0 %b expected 10", {resp1_val, resp0_val});
        end
        tick();
        memresp_val = 0;
        n_tests++;
        if (g0 !== 4 || g1 !== 4) begin
            n_fail++;
            $display("FAIL alt_share: g0 %0d g1 %0d expected 4 4", g0, g1);
        end
    endtask

    task automatic test_lock();
        logic [c_req_nbits-1:0] a, b;
        do_reset();
        a = mk_req(c_mem_type_write, 8'h0A, 32'h300, 32'h1234);
        b = mk_req(c_mem_type_read,  8'h0B, 32'h400, 32'h0);
        req1_val = 1; req1_msg = b; req0_msg = a; memreq_rdy = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req0_val = 1;
            #1;
            n_tests++;
            if (memreq_val !== 1'b1 || memreq_msg !== b || {req1_rdy, req0_rdy} !== 2'b00) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: val %b msg %h rdy %b expected 1 %h 00", c, memreq_val, memreq_msg, {req1_rdy, req0_rdy}, b);
            end
            tick();
        end
        memreq_rdy = 1;
        #1;
        n_tests++;
        if (memreq_msg !== b || {req1_rdy, req0_rdy} !== 2'b10) begin
            n_fail++;
            $display("FAIL lock_fire: msg %h rdy %b expected %h 10", memreq_msg, {req1_rdy, req0_rdy}, b);
        end
        tick();
        req1_val = 0;
        #1;
        n_tests++;
        if (memreq_msg !== a || {req1_rdy, req0_rdy} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_next: msg %h rdy %b expected %h 01", memreq_msg, {req1_rdy, req0_rdy}, a);
        end
        tick();
        req0_val = 0;
    endtask

    task automatic test_full();
        do_reset();
        memreq_rdy = 1; req0_val = 1; resp0_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            req0_msg = mk_req(c_mem_type_read, 8'(i), 32'h500 + 32'(4 * i), 32'h0);
            #1;
            n_tests++;
            if (req0_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL full_fill[%0d]: req0_rdy %b expected 1", i, req0_rdy);
            end
            tick();
        end
        req0_msg = mk_req(c_mem_type_read, 8'h44, 32'h510, 32'h0);
        #1;
        n_tests++;
        if ({memreq_val, req0_rdy} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_block: val/rdy %b expected 00", {memreq_val, req0_rdy});
        end
        memresp_val = 1; memresp_msg = mk_resp(c_mem_type_read, 8'h00, 32'h0);
        #1;
        n_tests++;
        if ({memreq_val, req0_rdy, memresp_rdy, resp0_val} !== 4'b0011) begin
            n_fail++;
            $display("FAIL full_no_bypass: val/rdy/mrdy/r0 %b expected 0011", {memreq_val, req0_rdy, memresp_rdy, resp0_val});
        end
        tick();
        memresp_val = 0;
        #1;
        n_tests++;
        if ({memreq_val, req0_rdy} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_resume: val/rdy %b expected 11", {memreq_val, req0_rdy});
        end
        tick();
        req0_val = 0;
    endtask

    task automatic test_no_reorder();
        logic [c_resp_nbits-1:0] r1, r0;
        do_reset();
        r1 = mk_resp(c_mem_type_read, 8'hB1, 32'h1111);
        r0 = mk_resp(c_mem_type_read, 8'hA0, 32'h0000_0A0A);
        memreq_rdy = 1;
        req1_val = 1; req1_msg = mk_req(c_mem_type_read, 8'hB1, 32'h600, 32'h0);
        tick();
        req1_val = 0;
        req0_val = 1; req0_msg = mk_req(c_mem_type_read, 8'hA0, 32'h700, 32'h0);
        tick();
        req0_val = 0;
        memresp_val = 1; memresp_msg = r1; resp0_rdy = 1; resp1_rdy = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++;
            if ({memresp_rdy, resp1_val, resp0_val} !== 3'b010) begin
                n_fail++;
                $display("FAIL order_stall[%0d]: mrdy/r1/r0 %b expected 010", c, {memresp_rdy, resp1_val, resp0_val});
            end
            tick();
        end
        resp1_rdy = 1;
        #1;
        n_tests++;
        if (memresp_rdy !== 1'b1 || resp1_msg !== r1) begin
            n_fail++;
            $display("FAIL order_release: mrdy %b msg %h expected 1 %h", memresp_rdy, resp1_msg, r1);
        end
        tick();
        memresp_msg = r0;
        #1;
        n_tests++;
        if ({memresp_rdy, resp1_val, resp0_val} !== 3'b101 || resp0_msg !== r0) begin
            n_fail++;
            $display("FAIL order_second: mrdy/r1/r0 %b msg %h expected 101 %h", {memresp_rdy, resp1_val, resp0_val}, resp0_msg, r0);
        end
        tick();
        memresp_val = 0;
    endtask

    task automatic test_async_reset();
        logic [c_req_nbits-1:0] a;
        do_reset();
        a = mk_req(c_mem_type_read, 8'h77, 32'h800, 32'h0);
        memreq_rdy = 1; req0_val = 1; req0_msg = a; resp0_rdy = 1; resp1_rdy = 1;
        tick();
        tick();
        memresp_val = 1; memresp_msg = mk_resp(c_mem_type_read, 8'h77, 32'h0);
        #2;
        n_tests++;
        if ({memreq_val, resp0_val} !== 2'b11) begin
            n_fail++;
            $display("FAIL areset_pre: val/r0 %b expected 11", {memreq_val, resp0_val});
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy} !== 6'b0) begin
            n_fail++;
            $display("FAIL areset_drop: outs %b expected 000000",
                     {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy});
        end
        memresp_val = 0; req0_val = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_val = 1; req1_val = 1;
        req1_msg = mk_req(c_mem_type_read, 8'h99, 32'h900, 32'h0);
        #1;
        n_tests++;
        if (memreq_msg !== a || {req1_rdy, req0_rdy} !== 2'b01) begin
            n_fail++;
            $display("FAIL areset_prio: msg %h rdy %b expected %h 01", memreq_msg, {req1_rdy, req0_rdy}, a);
        end
        req1_val = 0;
        @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) begin
            n_tests++;
            if (req0_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL areset_empty[%0d]: req0_rdy %b expected 1", i, req0_rdy);
            end
            tick();
        end
        n_tests++;
        if (req0_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_full: req0_rdy %b expected 0", req0_rdy);
        end
        req0_val = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_full();
        test_no_reorder();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
